// File: rtl/sram_ctrl_pkg.sv
// Shared types and sizing helpers for the SRAM access controller.
//   state_t     : controller sequencing states
//   addr_width  : row-address width for a given word count (minimum 1 bit)
//   cnt_width   : width of a counter that spans 0..n-1 (minimum 1 bit)
package sram_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SHIFT   = 3'd1,
        LOAD    = 3'd2,
        WRITE   = 3'd3,
        READ    = 3'd4,
        WAIT_RD = 3'd5,
        RESP    = 3'd6
    } state_t;

    function automatic int unsigned addr_width(input int unsigned rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sram_ctrl_ser.sv
// Parallel-in / serial-out helper for the SRAM write path.
// A COLS-bit word is loaded in one cycle and then presented MSB first,
// advancing one bit per cycle while i_shift is high.
//   clk, arst_n : clock, asynchronous active-low reset
//   i_load      : capture i_word and restart the bit counter
//   i_word      : word to serialise
//   i_shift     : advance to the next bit
//   o_bit       : bit currently presented (MSB of the remaining word)
//   o_done      : high while the final bit of the word is on o_bit
module sram_ctrl_ser
    import sram_ctrl_pkg::*;
#(
    parameter  int unsigned COLS = 4,
    localparam int unsigned CW   = cnt_width(COLS)
) (
    input  logic            clk,
    input  logic            arst_n,
    input  logic            i_load,
    input  logic [COLS-1:0] i_word,
    input  logic            i_shift,
    output logic            o_bit,
    output logic            o_done
);

    localparam logic [CW-1:0] LAST = CW'(COLS - 1);

    logic [COLS-1:0] r_sr;
    logic [CW-1:0]   r_cnt;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_sr  <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_sr  <= i_word;
            r_cnt <= '0;
        end else if (i_shift) begin
            r_sr  <= r_sr << 1;
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
        end
    end

    assign o_bit  = r_sr[COLS-1];
    assign o_done = (r_cnt == LAST);

endmodule

// File: rtl/sram_access_ctrl.sv
// Sequencer between a parallel request port and the serial-load SRAM macro.
// One accepted command is turned into the macro's shift/load/w_en or r_en
// sequence with the row address held steady, and exactly one response is
// returned per command.
//   clk, arst_n              : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready      : command handshake (ready only when idle)
//   cmd_we/cmd_addr/cmd_wdata: 1=write / 0=read, target row, write word
//   rsp_valid/rsp_ready      : response handshake, held until consumed
//   rsp_rdata/rsp_err        : read word (0 otherwise), range/timeout error
//   serial_in/shift/load     : macro shift-register data, enable, load strobe
//   w_en/r_en/addr           : macro write enable, read enable, row address
//   data_valid/data_out      : macro read return
module sram_access_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter  int unsigned ROWS       = 4,
    parameter  int unsigned COLS       = 4,
    parameter  int unsigned RD_TIMEOUT = 16,
    localparam int unsigned AW         = addr_width(ROWS)
) (
    input  logic            clk,
    input  logic            arst_n,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_we,
    input  logic [AW-1:0]   cmd_addr,
    input  logic [COLS-1:0] cmd_wdata,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [COLS-1:0] rsp_rdata,
    output logic            rsp_err,
    output logic            serial_in,
    output logic            shift,
    output logic            load,
    output logic            w_en,
    output logic            r_en,
    output logic [AW-1:0]   addr,
    input  logic            data_valid,
    input  logic [COLS-1:0] data_out
);

    localparam int unsigned   TW       = cnt_width(RD_TIMEOUT);
    localparam logic [TW-1:0] TMR_LAST = TW'(RD_TIMEOUT - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_live;     // low until the first clock after reset
    logic [AW-1:0]   r_addr;
    logic [TW-1:0]   r_tmr;      // cycles already spent in WAIT_RD
    logic [COLS-1:0] r_rdata;
    logic            r_err;

    logic            w_accept;
    logic            w_addr_oor;
    logic            w_ser_load;
    logic            w_ser_shift;
    logic            w_ser_bit;
    logic            w_ser_done;
    logic            w_timeout;
    logic            w_busy;

    assign w_addr_oor  = (32'(cmd_addr) >= ROWS);
    assign w_ser_load  = w_accept & cmd_we & ~w_addr_oor;
    // Taken straight from the state so the serialiser's done flag never
    // feeds back into the combinational block that produces the strobes.
    assign w_ser_shift = (r_state == SHIFT);

    sram_ctrl_ser #(
        .COLS (COLS)
    ) u_ser (
        .clk     (clk),
        .arst_n  (arst_n),
        .i_load  (w_ser_load),
        .i_word  (cmd_wdata),
        .i_shift (w_ser_shift),
        .o_bit   (w_ser_bit),
        .o_done  (w_ser_done)
    );

    // Next state and Moore outputs
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_timeout   = 1'b0;
        w_busy      = 1'b0;
        cmd_ready   = 1'b0;
        rsp_valid   = 1'b0;
        shift       = 1'b0;
        serial_in   = 1'b0;
        load        = 1'b0;
        w_en        = 1'b0;
        r_en        = 1'b0;

        unique case (r_state)
            IDLE: begin
                cmd_ready = r_live;
                if (cmd_valid && r_live) begin
                    w_accept = 1'b1;
                    if (w_addr_oor) begin
                        w_state_nxt = RESP;
                    end else if (cmd_we) begin
                        w_state_nxt = SHIFT;
                    end else begin
                        w_state_nxt = READ;
                    end
                end
            end
            SHIFT: begin
                w_busy    = 1'b1;
                shift     = 1'b1;
                serial_in = w_ser_bit;
                if (w_ser_done) begin
                    w_state_nxt = LOAD;
                end
            end
            LOAD: begin
                w_busy      = 1'b1;
                load        = 1'b1;
                w_state_nxt = WRITE;
            end
            WRITE: begin
                w_busy      = 1'b1;
                w_en        = 1'b1;
                w_state_nxt = RESP;
            end
            READ: begin
                w_busy      = 1'b1;
                r_en        = 1'b1;
                w_state_nxt = WAIT_RD;
            end
            WAIT_RD: begin
                w_busy = 1'b1;
                // Data arriving on the final allowed cycle still counts.
                if (data_valid) begin
                    w_state_nxt = RESP;
                end else if (r_tmr == TMR_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state <= IDLE;
            r_live  <= 1'b0;
            r_addr  <= '0;
            r_tmr   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_live  <= 1'b1;

            if (w_accept) begin
                r_addr  <= cmd_addr;
                r_tmr   <= '0;
                r_rdata <= '0;
                r_err   <= w_addr_oor;
            end

            if (r_state == WAIT_RD) begin
                if (data_valid) begin
                    r_rdata <= data_out;
                    r_err   <= 1'b0;
                end else if (w_timeout) begin
                    r_err   <= 1'b1;
                end else begin
                    r_tmr   <= r_tmr + TW'(1);
                end
            end

            if (rsp_valid && rsp_ready) begin
                r_addr  <= '0;
                r_rdata <= '0;
                r_err   <= 1'b0;
            end
        end
    end

    assign addr      = w_busy ? r_addr : '0;
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

    a_strobe_excl: assert property (@(posedge clk) disable iff (!arst_n)
        $onehot0({shift, load, w_en, r_en}));

    a_addr_hold: assert property (@(posedge clk) disable iff (!arst_n)
        (w_busy && $past(w_busy)) |-> (addr == $past(addr)));

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Bench for sram_access_ctrl (ROWS=5 so the out-of-range path is reachable).
// The bench acts as the SRAM macro (shift register, load latch, word array)
// and keeps a word-level reference memory that is updated per completed write.
module tb_sram_access_ctrl;

    localparam int unsigned ROWS       = 5;
    localparam int unsigned COLS       = 4;
    localparam int unsigned RD_TIMEOUT = 16;
    localparam int unsigned AW         = sram_ctrl_pkg::addr_width(ROWS);

    logic            clk        = 1'b0;
    logic            arst_n     = 1'b0;
    logic            cmd_valid  = 1'b0;
    logic            cmd_we     = 1'b0;
    logic [AW-1:0]   cmd_addr   = '0;
    logic [COLS-1:0] cmd_wdata  = '0;
    logic            rsp_ready  = 1'b0;
    logic            data_valid = 1'b0;
    logic [COLS-1:0] data_out   = '0;
    logic            cmd_ready;
    logic            rsp_valid;
    logic [COLS-1:0] rsp_rdata;
    logic            rsp_err;
    logic            serial_in;
    logic            shift;
    logic            load;
    logic            w_en;
    logic            r_en;
    logic [AW-1:0]   addr;

    int n_checks = 0;
    int n_fail   = 0;

    logic [COLS-1:0] ref_mem [0:7] = '{default: '0};
    logic [COLS-1:0] m_mem   [0:7] = '{default: '0};
    logic [COLS-1:0] m_sr    = '0;
    logic [COLS-1:0] m_latch = '0;

    typedef struct {
        logic            we;
        logic [AW-1:0]   addr;
        logic [COLS-1:0] wd;
        int              dv;    // data_valid this many cycles after r_en; 0 = never
        int              rr;    // cycles rsp_ready is held low
        int              lat;   // accept -> rsp_valid cycles
        logic            err;
        logic [COLS-1:0] rd;
    } vec_t;

    vec_t tbl [0:10];

    sram_access_ctrl #(
        .ROWS       (ROWS),
        .COLS       (COLS),
        .RD_TIMEOUT (RD_TIMEOUT)
    ) dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_we     (cmd_we),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .serial_in  (serial_in),
        .shift      (shift),
        .load       (load),
        .w_en       (w_en),
        .r_en       (r_en),
        .addr       (addr),
        .data_valid (data_valid),
        .data_out   (data_out)
    );

    always #5 clk = ~clk;

    // Macro behaviour: shift register, parallel load latch, word array
    always @(posedge clk) begin
        if (shift) m_sr <= {m_sr[COLS-2:0], serial_in};
        if (load)  m_latch <= m_sr;
        if (w_en)  m_mem[addr] <= m_latch;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // {rsp_valid, cmd_ready, shift, load, w_en, r_en, serial_in}
    function automatic logic [6:0] outs();
        return {rsp_valid, cmd_ready, shift, load, w_en, r_en, serial_in};
    endfunction

    // Expected strobes n cycles after accept, before the response
    function automatic logic [6:0] exp_busy(input logic we, input logic [COLS-1:0] wd, input int n);
        if (we) begin
            if (n <= int'(COLS)) return {2'b00, 1'b1, 3'b000, wd[int'(COLS) - n]};
            if (n == int'(COLS) + 1) return 7'b0001000;
            if (n == int'(COLS) + 2) return 7'b0000100;
        end else if (n == 1) begin
            return 7'b0000010;
        end
        return '0;
    endfunction

    task automatic run_cmd(input logic we, input logic [AW-1:0] a, input logic [COLS-1:0] wd,
                           input int dv, input int rr, input int lat, input logic xerr,
                           input logic [COLS-1:0] xrd, input string tag);
        int   waited;
        logic oor;
        waited = 0;
        oor    = (32'(a) >= ROWS);
        while (!cmd_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        chk({tag, " ready"}, 32'(cmd_ready), 32'd1);
        cmd_valid  = 1'b1;
        cmd_we     = we;
        cmd_addr   = a;
        cmd_wdata  = wd;
        rsp_ready  = 1'b0;
        data_valid = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_we    = 1'($urandom);
        cmd_addr  = AW'($urandom);
        cmd_wdata = COLS'($urandom);
        for (int n = 1; n < lat; n++) begin
            chk($sformatf("%s c%0d strobes", tag, n), 32'(outs()), 32'(exp_busy(we, wd, n)));
            chk($sformatf("%s c%0d addr", tag, n), 32'(addr), 32'(a));
            data_out  = COLS'($urandom);
            rsp_ready = 1'($urandom);
            if (we || oor || n == 1) begin
                data_valid = 1'($urandom);
            end else if (dv > 0 && n == dv + 1) begin
                data_valid = 1'b1;
                data_out   = m_mem[a];
            end else begin
                data_valid = 1'b0;
            end
            @(negedge clk);
        end
        for (int h = 0; h <= rr; h++) begin
            chk($sformatf("%s rsp%0d outs", tag, h), 32'(outs()), 32'h40);
            chk($sformatf("%s rsp%0d err", tag, h), 32'(rsp_err), 32'(xerr));
            chk($sformatf("%s rsp%0d rdata", tag, h), 32'(rsp_rdata), 32'(xrd));
            data_valid = (h == 0) ? 1'b1 : 1'($urandom);
            data_out   = COLS'($urandom);
            if (h < rr) begin
                rsp_ready = 1'b0;
                cmd_valid = 1'b1;
                cmd_we    = 1'($urandom);
                cmd_addr  = AW'($urandom);
                cmd_wdata = COLS'($urandom);
            end else begin
                rsp_ready = 1'b1;
                cmd_valid = 1'b0;
            end
            @(negedge clk);
        end
        rsp_ready  = 1'b0;
        data_valid = 1'b0;
        chk({tag, " done"}, 32'({outs(), rsp_err, rsp_rdata}), 32'({7'b0100000, 1'b0, {COLS{1'b0}}}));
        if (we && !oor) ref_mem[a] = wd;
    endtask

    initial begin
        logic            we_r;
        logic            oor_r;
        logic            in_time;
        logic            err_r;
        logic [AW-1:0]   a_r;
        logic [COLS-1:0] wd_r;
        logic [COLS-1:0] rd_r;
        int              dv_r;
        int              rr_r;
        int              lat_r;

        //           we    addr  wd     dv  rr lat err   rd
        tbl[0]  = '{1'b1, 3'd2, 4'hB,  0, 0,  7, 1'b0, 4'h0};
        tbl[1]  = '{1'b0, 3'd2, 4'h0,  2, 0,  4, 1'b0, 4'hB};
        tbl[2]  = '{1'b0, 3'd2, 4'h0,  0, 0, 18, 1'b1, 4'h0};
        tbl[3]  = '{1'b0, 3'd2, 4'h0, 16, 0, 18, 1'b0, 4'hB};
        tbl[4]  = '{1'b1, 3'd6, 4'h3,  0, 0,  1, 1'b1, 4'h0};
        tbl[5]  = '{1'b0, 3'd5, 4'h0,  2, 0,  1, 1'b1, 4'h0};
        tbl[6]  = '{1'b1, 3'd4, 4'h5,  0, 5,  7, 1'b0, 4'h0};
        tbl[7]  = '{1'b0, 3'd4, 4'h0,  1, 2,  3, 1'b0, 4'h5};
        tbl[8]  = '{1'b0, 3'd4, 4'h0, 17, 0, 18, 1'b1, 4'h0};
        tbl[9]  = '{1'b1, 3'd0, 4'h0,  0, 1,  7, 1'b0, 4'h0};
        tbl[10] = '{1'b0, 3'd0, 4'h0,  3, 0,  5, 1'b0, 4'h0};

        // Reset state
        @(negedge clk);
        chk("reset outs", 32'({outs(), addr, rsp_err, rsp_rdata}), 32'd0);
        @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);
        chk("post-reset ready", 32'(outs()), 32'h20);

        for (int i = 0; i <= 10; i++) begin
            run_cmd(tbl[i].we, tbl[i].addr, tbl[i].wd, tbl[i].dv, tbl[i].rr,
                    tbl[i].lat, tbl[i].err, tbl[i].rd, $sformatf("vec%0d", i));
        end

        // Reset while the third bit of a write is being shifted
        cmd_valid = 1'b1;
        cmd_we    = 1'b1;
        cmd_addr  = 3'd3;
        cmd_wdata = 4'b0010;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort pre", 32'({outs(), addr}), 32'({7'b0010001, 3'd3}));
        #1 arst_n = 1'b0;
        #1 chk("abort immediate", 32'({outs(), addr, rsp_err, rsp_rdata}), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("abort hold%0d", k), 32'({outs(), addr, rsp_err, rsp_rdata}), 32'd0);
        end
        arst_n = 1'b1;
        @(negedge clk);
        chk("abort release", 32'(outs()), 32'h20);
        run_cmd(1'b0, 3'd3, 4'h0, 2, 0, 4, 1'b0, ref_mem[3], "abort rd-before");
        run_cmd(1'b1, 3'd3, 4'h6, 0, 0, 7, 1'b0, 4'h0, "abort wr");
        run_cmd(1'b0, 3'd3, 4'h0, 2, 0, 4, 1'b0, 4'h6, "abort rd-after");

        // Randomised commands against the word-level reference memory
        for (int k = 0; k < 40; k++) begin
            we_r    = (k < int'(ROWS)) ? 1'b1 : 1'($urandom);
            a_r     = (k < int'(ROWS)) ? AW'(k) : AW'($urandom_range(0, 7));
            wd_r    = COLS'($urandom);
            dv_r    = int'($urandom_range(0, 19));
            rr_r    = int'($urandom_range(0, 3));
            oor_r   = (32'(a_r) >= ROWS);
            in_time = (dv_r >= 1) && (dv_r <= int'(RD_TIMEOUT));
            if (oor_r)        lat_r = 1;
            else if (we_r)    lat_r = int'(COLS) + 3;
            else if (in_time) lat_r = dv_r + 2;
            else              lat_r = int'(RD_TIMEOUT) + 2;
            err_r = oor_r || (!we_r && !in_time);
            rd_r  = (!oor_r && !we_r && in_time) ? ref_mem[a_r] : '0;
            run_cmd(we_r, a_r, wd_r, dv_r, rr_r, lat_r, err_r, rd_r, $sformatf("rnd%0d", k));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
